// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multi-cycle exception takeover sequencer for the multicycle MIPS datapath
module exception_sequencer #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_opcode,
    input  logic             req_ovf,
    input  logic [31:0]      mem_data,
    output logic             busy,
    output logic             alu_pc_minus4,
    output logic             epc_write,
    output logic             cause_write,
    output logic             int_cause,
    output logic [1:0]       iou_d,
    output logic             pc_write,
    output logic [31:0]      handler_pc,
    output logic [CNT_W-1:0] exc_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SAVE  = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        JUMP  = 3'd4
    } seqState_t;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

    seqState_t        stateQ, stateD;
    logic [2:0]       waitQ, waitD;
    logic             causeQ, causeD;
    logic [7:0]       vecQ, vecD;
    logic [CNT_W-1:0] countQ, countD;

    // Only the handler byte matters; the upper read bits are deliberately dropped.
    logic unusedMemBits;
    assign unusedMemBits = ^mem_data[31:8];

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ <= IDLE;
            waitQ  <= 3'd0;
            causeQ <= 1'b0;
            vecQ   <= 8'd0;
            countQ <= '0;
        end else begin
            stateQ <= stateD;
            waitQ  <= waitD;
            causeQ <= causeD;
            vecQ   <= vecD;
            countQ <= countD;
        end
    end

    always_comb begin
        stateD = stateQ;
        waitD  = waitQ;
        causeD = causeQ;
        vecD   = vecQ;
        countD = countQ;
        case (stateQ)
            IDLE: begin
                // Opcode fault wins when both requests arrive together.
                if (req_opcode || req_ovf) begin
                    stateD = SAVE;
                    causeD = !req_opcode;
                    countD = countQ + CNT_W'(1);
                end
            end
            SAVE: begin
                waitD  = WAIT_INIT;
                stateD = FETCH;
            end
            FETCH: begin
                if (waitQ == 3'd0) begin
                    stateD = LOAD;
                end else begin
                    waitD = waitQ - 3'd1;
                end
            end
            LOAD: begin
                vecD   = mem_data[7:0];
                stateD = JUMP;
            end
            JUMP: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Every output is a pure decode of registered state, so nothing leaks from the request inputs.
    assign busy          = (stateQ != IDLE);
    assign alu_pc_minus4 = (stateQ == SAVE);
    assign epc_write     = (stateQ == SAVE);
    assign cause_write   = (stateQ == SAVE);
    assign int_cause     = causeQ;
    assign iou_d         = (stateQ == FETCH || stateQ == LOAD) ? 2'b10 : 2'b00;
    assign pc_write      = (stateQ == JUMP);
    assign handler_pc    = {24'd0, vecQ};
    assign exc_count     = countQ;
    assign state         = stateQ;

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - randomized scoreboard bench for exception_sequencer
module tb_exception_sequencer;

    localparam int MW = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqOpcode, reqOvf;
    logic [31:0] memData;
    logic        busy, aluPcMinus4, epcWrite, causeWrite, intCause, pcWrite;
    logic [1:0]  iouD;
    logic [31:0] handlerPc;
    logic [7:0]  excCount;
    logic [2:0]  stateOut;

    logic        reqOvf1;
    logic [31:0] memData1;
    logic        busy1, alu1, epc1, cause1, intCause1, pcWrite1;
    logic [1:0]  iouD1;
    logic [31:0] handlerPc1;
    logic [7:0]  excCount1;
    logic [2:0]  state1;

    always #5 clock = ~clock;

    exception_sequencer #(.MEM_WAIT(MW), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .req_opcode(reqOpcode), .req_ovf(reqOvf),
        .mem_data(memData), .busy(busy), .alu_pc_minus4(aluPcMinus4),
        .epc_write(epcWrite), .cause_write(causeWrite), .int_cause(intCause),
        .iou_d(iouD), .pc_write(pcWrite), .handler_pc(handlerPc),
        .exc_count(excCount), .state(stateOut)
    );

    exception_sequencer #(.MEM_WAIT(1), .CNT_W(8)) dut1 (
        .clock(clock), .reset(reset), .req_opcode(1'b0), .req_ovf(reqOvf1),
        .mem_data(memData1), .busy(busy1), .alu_pc_minus4(alu1),
        .epc_write(epc1), .cause_write(cause1), .int_cause(intCause1),
        .iou_d(iouD1), .pc_write(pcWrite1), .handler_pc(handlerPc1),
        .exc_count(excCount1), .state(state1)
    );

    // Environment: vector memory and the EPC register of the datapath
    logic [7:0]  vecMem [2];
    logic [23:0] memUpper;
    logic [31:0] pcReg, epcReg;
    assign memData  = (iouD == 2'b10) ? {memUpper, vecMem[intCause]} : 32'h0;
    assign memData1 = 32'hFFFF_FF33;

    always @(posedge clock) begin
        if (epcWrite && aluPcMinus4) epcReg <= pcReg - 32'd4;
    end

    typedef struct {
        int          cyc;
        logic [31:0] hpc;
        logic        cause;
        logic [7:0]  cnt;
        logic [31:0] epc;
    } exp_t;
    exp_t sbq[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lastAccept = -100;
    int          idleFrom = 0;
    logic [7:0]  expCount = 8'd0;
    logic        expCause = 1'b0;
    logic [31:0] nextPc;
    logic [7:0]  nextV254, nextV255;
    logic [23:0] nextUpper;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected debug state from the documented timeline, d = cycles since request accepted
    function automatic logic [2:0] expState(input int d);
        if (d == 1) return 3'd1;
        if (d >= 2 && d <= 1 + MW) return 3'd2;
        if (d == 2 + MW) return 3'd3;
        if (d == 3 + MW) return 3'd4;
        return 3'd0;
    endfunction

    // One cycle of stimulus plus the reference model's view of acceptance
    task automatic step(input logic o, input logic v, input logic rst);
        exp_t e;
        @(negedge clock);
        #1;
        reset     = rst;
        reqOpcode = o;
        reqOvf    = v;
        if (rst) begin
            sbq.delete();
            expCount   = 8'd0;
            expCause   = 1'b0;
            lastAccept = -100;
            idleFrom   = cyc + 1;
        end else if ((o || v) && cyc >= idleFrom) begin
            pcReg      = nextPc;
            vecMem[0]  = nextV254;
            vecMem[1]  = nextV255;
            memUpper   = nextUpper;
            expCause   = o ? 1'b0 : 1'b1;
            expCount   = expCount + 8'd1;
            lastAccept = cyc;
            idleFrom   = cyc + MW + 4;
            e.cyc   = cyc + 3 + MW;
            e.hpc   = {24'd0, expCause ? nextV255 : nextV254};
            e.cause = expCause;
            e.cnt   = expCount;
            e.epc   = nextPc - 32'd4;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle control-line checks plus scoreboard pop on pc_write
    always @(negedge clock) begin
        logic [2:0] es;
        exp_t e;
        cyc = cyc + 1;
        es = expState(cyc - lastAccept);
        check("state", {29'd0, stateOut}, {29'd0, es});
        check("busy", {31'd0, busy}, {31'd0, es != 3'd0});
        check("iou_d", {30'd0, iouD}, (es == 3'd2 || es == 3'd3) ? 32'd2 : 32'd0);
        check("save_strobes", {29'd0, epcWrite, aluPcMinus4, causeWrite}, (es == 3'd1) ? 32'd7 : 32'd0);
        check("int_cause", {31'd0, intCause}, {31'd0, expCause});
        check("exc_count", {24'd0, excCount}, {24'd0, expCount});
        if (pcWrite === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_pc_write", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("jump_cycle", cyc, e.cyc);
                check("handler_pc", handlerPc, e.hpc);
                check("jump_cause", {31'd0, intCause}, {31'd0, e.cause});
                check("jump_count", {24'd0, excCount}, {24'd0, e.cnt});
                check("epc", epcReg, e.epc);
            end
        end
    end

    initial begin
        int c, jumpAt;
        logic [2:0]  jumpState;
        logic [31:0] jumpHpc;
        logic        jumpCause;
        reset = 1'b1; reqOpcode = 1'b0; reqOvf = 1'b0; reqOvf1 = 1'b0;
        vecMem[0] = 8'h0; vecMem[1] = 8'h0; memUpper = 24'h0; pcReg = 32'h0;
        nextPc = 32'h0; nextV254 = 8'h0; nextV255 = 8'h0; nextUpper = 24'h0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("reset_handler_pc", handlerPc, 32'h0);
        check("reset_pc_write", {31'd0, pcWrite}, 32'd0);

        // invalid opcode, PC=0x10, mem[254]=0x40
        nextPc = 32'h10; nextV254 = 8'h40; nextV255 = 8'h55; nextUpper = 24'h0;
        step(1'b1, 1'b0, 1'b0);
        idle(8);
        // overflow with upper read bits set
        nextPc = 32'h200; nextV254 = 8'h11; nextV255 = 8'h80; nextUpper = 24'hFFFFFF;
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        // simultaneous requests
        nextPc = 32'h300; nextV254 = 8'h22; nextV255 = 8'h99; nextUpper = 24'hA5A5A5;
        step(1'b1, 1'b1, 1'b0);
        idle(8);
        // overflow pulses in FETCH and JUMP are ignored
        nextPc = 32'h400; nextV254 = 8'h33; nextV255 = 8'h44;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        // reset in the second FETCH cycle
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("abort_state", {29'd0, stateOut}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_count", {24'd0, excCount}, 32'd0);
        idle(8);

        // randomized requests, including pulses while busy
        for (int i = 0; i < 500; i++) begin
            nextPc    = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'd4;
            nextV254  = 8'($urandom);
            nextV255  = 8'($urandom);
            nextUpper = 24'($urandom);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0);
        end
        idle(8);

        // 256 back-to-back exceptions wrap the counter
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 256 * (MW + 4); i++) begin
            nextPc = 32'h1000 + 32'(i); nextV254 = 8'(i); nextV255 = 8'h0;
            step(1'b1, 1'b0, 1'b0);
        end
        idle(MW + 4);
        check("wrap_count", {24'd0, excCount}, 32'd0);

        // MEM_WAIT=1 instance: JUMP in cycle 4 after the request
        step(1'b0, 1'b0, 1'b0);
        c = cyc;
        reqOvf1 = 1'b1;
        jumpAt = -1; jumpState = 3'd0; jumpHpc = 32'h0; jumpCause = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            reqOvf1 = 1'b0;
            if (pcWrite1 === 1'b1 && jumpAt < 0) begin
                jumpAt = cyc - c; jumpState = state1; jumpHpc = handlerPc1; jumpCause = intCause1;
            end
        end
        check("mw1_jump_cycle", jumpAt, 32'd4);
        check("mw1_jump_state", {29'd0, jumpState}, 32'd4);
        check("mw1_handler_pc", jumpHpc, 32'h33);
        check("mw1_cause", {31'd0, jumpCause}, 32'd1);
        check("mw1_count", {24'd0, excCount1}, 32'd1);

        check("scoreboard_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Multi-cycle exception sequencer for the multicycle MIPS datapath. When the main control unit flags an invalid opcode or the ALU flags arithmetic overflow, this block takes over the datapath for a fixed sequence:
- saves PC-4 into EPC and the cause code into Cause;
- fetches the handler byte from the exception vector location through the IouD=2 memory path;
- loads the zero-extended byte into PC.

It sits beside the main control unit. Its outputs are OR'd or muxed onto the datapath control lines while `busy` is high.

## Interface
- MEM_WAIT, 2, memory read latency in cycles between a stable address and valid `mem_data`; legal range 1..7.
- CNT_W, 8, width of the exception event counter.

- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req_opcode  in  1  invalid-opcode request from control unit, level, sampled only in IDLE
- req_ovf  in  1  overflow request (ALU overflow on signed arith instr), level, sampled only in IDLE
- mem_data  in  32  memory read data; bits [7:0] hold handler address byte
- busy  out  1  high in every state except IDLE; control unit must hold its state while high
- alu_pc_minus4  out  1  datapath selects OrigAALU=PC, OrigBALU=const 4, ALU op=subtract
- epc_write  out  1  EPC load enable (EPC takes ALU result)
- cause_write  out  1  Cause load enable
- int_cause  out  1  cause code: 0 = invalid opcode (vector 254), 1 = overflow (vector 255); also drives INTERRUPTION address block
- iou_d  out  2  memory address select; 2'b10 = vector address during fetch, else 2'b00
- pc_write  out  1  PC load enable for handler_pc
- handler_pc  out  32  {24'b0, latched vector byte}
- exc_count  out  CNT_W  number of exceptions taken, wraps to 0
- state  out  3  encoded state for debug: IDLE=0, SAVE=1, FETCH=2, LOAD=3, JUMP=4

## Operation
- IDLE: all strobes low, iou_d=0. If req_opcode or req_ovf is high at the clock edge, go to SAVE.
  - int_cause register ← 0 if req_opcode, else 1. Opcode has priority on simultaneous requests.
  - exc_count increments.
- SAVE (1 cycle): alu_pc_minus4=1, epc_write=1, cause_write=1. Wait counter ← MEM_WAIT-1. Go to FETCH.
- FETCH (MEM_WAIT cycles): iou_d=2'b10. Counter decrements each cycle; exit to LOAD when it is 0.
- LOAD (1 cycle): iou_d=2'b10 held. vec register ← mem_data[7:0] at end of cycle. Go to JUMP.
- JUMP (1 cycle): pc_write=1, handler_pc valid. Go to IDLE.
- int_cause stays constant from SAVE through JUMP and holds its last value in IDLE.
- Requests arriving while not in IDLE are ignored. They are not queued and exc_count does not change.
- Requests still high on return to IDLE start a new sequence. The control unit must drop the request once busy is seen.
- Bits mem_data[31:8] are ignored.
- exc_count is CNT_W bits and wraps from all-ones to 0 with no flag.

## Timing
- Reset values: state=IDLE, busy=0, every strobe=0, iou_d=0, int_cause=0, handler_pc=0, vec=0, exc_count=0, wait counter=0.
- Reset asserted in any state returns the block to IDLE at the next edge with reset values. No partial write is completed afterwards.
- All outputs are decoded from registered state only. They are glitch-free and have no combinational path from the inputs.
- Request high in cycle 0 (IDLE), then:
  - SAVE in cycle 1;
  - FETCH in cycles 2..1+MEM_WAIT;
  - LOAD in cycle 2+MEM_WAIT;
  - JUMP in cycle 3+MEM_WAIT;
  - IDLE in cycle 4+MEM_WAIT.
- With MEM_WAIT=2: pc_write is high in cycle 5, and busy is high for 5 cycles.
- The memory address (iou_d=2) is stable for MEM_WAIT+1 consecutive cycles before mem_data is sampled.
- epc_write and alu_pc_minus4 are coincident for exactly one cycle, so EPC captures PC-4 of the faulting instruction's fetch-incremented PC.

## Test plan
- Invalid opcode, MEM_WAIT=2, PC=0x0000_0010, mem[254]=0x40:
  - cycle 1: epc_write=1, int_cause=0;
  - iou_d=2 for cycles 2-4;
  - cycle 5: pc_write=1, handler_pc=0x0000_0040;
  - EPC=0x0000_000C, exc_count=1.
- Overflow, mem[255]=0x80, mem_data upper bits=0xFFFFFF: int_cause=1, handler_pc=0x0000_0080 (upper bits masked).
- req_opcode and req_ovf both high in the same IDLE cycle: int_cause=0, vector 254 fetched, exc_count increments by 1.
- req_ovf pulsed during FETCH and JUMP: no effect. Sequence completes unchanged, exc_count unchanged.
- reset asserted in the second FETCH cycle: next cycle state=0, busy=0, pc_write never asserts, exc_count=0.
- With CNT_W=8: 256 back-to-back exceptions make exc_count wrap to 0x00. Repeat with MEM_WAIT=1 and check that JUMP falls in cycle 4.
